fft_in_loader: RTL



---
 rtl/fft_in_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fft_in_loader.sv
// +---------------------------------------------------------------------------+
// | fft_in_loader: collects an N-sample real frame and replays it into the    |
// | FFT controller load port, then pulses start and waits for the output      |
// | side to capture the result. Option macro: FFT_IN_PINGPONG_EN (two banks).  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module fft_in_loader #(
  parameter int N        = 64,
  parameter int ADDR_W   = 6,
  parameter int SAMPLE_W = 16
) (
  input  logic                  slow_clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [SAMPLE_W-1:0]   sample,
  output logic                  sample_ready,
  input  logic                  out_buf_ready,
  output logic                  fft_load,
  output logic                  fft_start,
  output logic [ADDR_W-1:0]     fft_rd_adr,
  output logic [2*SAMPLE_W-1:0] fft_rd,
  output logic                  busy,
  output logic [7:0]            overrun_cnt
);

`ifdef FFT_IN_PINGPONG_EN
  localparam int IDX_W = ADDR_W + 1;
`else
  localparam int IDX_W = ADDR_W;
`endif
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [SAMPLE_W-1:0] sample_buf [DEPTH];
  logic [ADDR_W-1:0]   fill_cnt, load_cnt, next_k;
  logic [IDX_W-1:0]    wr_idx, first_idx, next_idx;
  logic                obr_q, rise, transfer, last, handoff;

`ifdef FFT_IN_PINGPONG_EN
  logic fill_bank, load_bank, pending, pending_n;

  assign wr_idx    = {fill_bank, fill_cnt};
  assign first_idx = {fill_bank, {ADDR_W{1'b0}}};
  assign next_idx  = {load_bank, next_k};
`else
  assign wr_idx    = fill_cnt;
  assign first_idx = '0;
  assign next_idx  = next_k;
`endif

  assign transfer = sample_valid && sample_ready;
  assign last     = transfer && (fill_cnt == ADDR_W'(N - 1));
  assign rise     = out_buf_ready && !obr_q;
  assign next_k   = load_cnt + ADDR_W'(1);

  // handoff marks the edge where a completed bank is given to the replay side
  always_comb begin
    state_n = state;
    handoff = 1'b0;
    case (state)
      ST_FILL: begin
        if (last) begin
          state_n = ST_LOAD;
          handoff = 1'b1;
        end
      end
      ST_LOAD: begin
        if (load_cnt == ADDR_W'(N - 1)) state_n = ST_START;
      end
      ST_START: state_n = ST_WAIT;
      ST_WAIT: begin
        if (rise) begin
`ifdef FFT_IN_PINGPONG_EN
          if (pending || last) begin
            state_n = ST_LOAD;
            handoff = 1'b1;
          end else begin
            state_n = ST_FILL;
          end
`else
          state_n = ST_FILL;
`endif
        end
      end
      default: state_n = ST_FILL;
    endcase
  end

`ifdef FFT_IN_PINGPONG_EN
  always_comb begin
    pending_n = pending;
    if (handoff)   pending_n = 1'b0;
    else if (last) pending_n = 1'b1;
  end
`endif

  always_ff @(posedge slow_clk) begin
    if (reset && transfer) sample_buf[wr_idx] <= sample;
  end

  always_ff @(posedge slow_clk) begin
    obr_q <= out_buf_ready;
    if (!reset) begin
      state        <= ST_FILL;
      fill_cnt     <= '0;
      load_cnt     <= '0;
      sample_ready <= 1'b1;
      fft_load     <= 1'b0;
      fft_start    <= 1'b0;
      fft_rd_adr   <= '0;
      fft_rd       <= '0;
      busy         <= 1'b0;
      overrun_cnt  <= '0;
`ifdef FFT_IN_PINGPONG_EN
      fill_bank    <= 1'b0;
      load_bank    <= 1'b0;
      pending      <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (transfer) fill_cnt <= fill_cnt + ADDR_W'(1);
      if (sample_valid && !sample_ready && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;
      fft_load  <= (state_n == ST_LOAD);
      fft_start <= (state_n == ST_START);
      busy      <= (state_n != ST_FILL);
      if (handoff) begin
        load_cnt   <= '0;
        fft_rd_adr <= '0;
        fft_rd     <= {sample_buf[first_idx], {SAMPLE_W{1'b0}}};
      end else if (state_n == ST_LOAD) begin
        load_cnt   <= next_k;
        fft_rd_adr <= next_k;
        fft_rd     <= {sample_buf[next_idx], {SAMPLE_W{1'b0}}};
      end else begin
        fft_rd_adr <= '0;
        fft_rd     <= '0;
      end
`ifdef FFT_IN_PINGPONG_EN
      pending      <= pending_n;
      sample_ready <= !pending_n;
      if (handoff) begin
        load_bank <= fill_bank;
        fill_bank <= ~fill_bank;
      end
`else
      sample_ready <= (state_n == ST_FILL);
`endif
    end
  end

endmodule

`default_nettype wire
